udp_payload_pingpong: RTL
=========================

// Module: udp_payload_pingpong
// PURPOSE
//  Parametrised payload store between the GMII UDP rx/tx engine and the sender, all in the e_rxc domain.
//  Two RAM banks run ping-pong: the rx engine fills one bank while the sender reads the other.
//  After reset, bank 0 is preloaded with a default payload, so the board answers before any frame arrives.
//  The block also owns tx_total_length / tx_data_length, which hold the defaults until the first received frame.
// PARAMETERS
//  DATA_W        32  RAM word width
//  ADDR_W        9   word address width per bank; physical RAM depth 2^(ADDR_W+1)
//  DEF_WORDS     5   number of default payload words preloaded to bank 0, addresses 0..DEF_WORDS-1
//  DEF_TOTAL_LEN 48  tx_total_length value after reset
//  DEF_DATA_LEN  28  tx_data_length value after reset
// PORTS
//  clk             in   1       e_rxc, 125 MHz, all logic on the rising edge
//  reset_n         in   1       reset, synchronous, active-low
//  rx_wr_en        in   1       rx engine word write strobe
//  rx_wr_addr      in   ADDR_W  word address within the current write bank
//  rx_wr_data      in   DATA_W  word from the rx engine
//  rx_frame_done   in   1       1-cycle pulse: last word of a valid UDP frame has been written
//  rx_total_length in   16      IP total length of that frame, valid with rx_frame_done
//  rx_data_length  in   16      UDP length of that frame, valid with rx_frame_done
//  tx_start        in   1       1-cycle pulse: sender begins reading the payload
//  tx_done         in   1       1-cycle pulse: sender has finished the frame
//  tx_rd_addr      in   ADDR_W  word address within the current read bank
//  tx_rd_data      out  DATA_W  RAM word; registered, valid 1 cycle after tx_rd_addr
//  tx_total_length out  16      length the sender uses
//  tx_data_length  out  16      length the sender uses
//  init_done       out  1       high once the preload is complete
//  frame_received  out  1       sticky; set by the first accepted frame
//  drop_cnt        out  8       saturating count of frames dropped
// BEHAVIOUR
//  Reset values
//   init_done=0, frame_received=0, drop_cnt=0, wr_bank=1, rd_bank=0, busy=0, pending=0.
//   tx_total_length=DEF_TOTAL_LEN, tx_data_length=DEF_DATA_LEN, tx_rd_data=0.
//  State S_INIT
//   Writes one word per cycle: word k to physical address {0,k}, k=0..DEF_WORDS-1.
//   Then moves to S_RUN and raises init_done in the same cycle the FSM enters S_RUN.
//   Takes exactly DEF_WORDS cycles after reset release.
//   rx_wr_en, rx_frame_done and tx_start are ignored in S_INIT.
//  State S_RUN: write port
//   Write port = {wr_bank, rx_wr_addr}; rx writes are accepted only when pending=0.
//  State S_RUN: read port
//   Read port = {rd_bank, tx_rd_addr} in every state; no read/write collision is possible
//   because wr_bank != rd_bank always.
//  busy
//   tx_start sets busy; tx_done clears it. tx_start while busy=1 is ignored.
//  rx_frame_done, pending=0
//   Capture both rx lengths into shadow registers.
//   If busy=0 and no tx_start this cycle: swap next edge (rd_bank<=wr_bank, wr_bank<=rd_bank,
//   tx lengths<=shadow, frame_received<=1).
//   Otherwise set pending=1.
//  rx_frame_done, pending=1
//   Frame dropped, shadow kept, drop_cnt+1 (saturates at 255).
//  pending=1 and tx_done
//   Swap on the next edge, pending<=0. If tx_done and rx_frame_done arrive in the same cycle,
//   the swap happens and the new rx_frame_done counts as dropped.
//  Simultaneous tx_start + rx_frame_done
//   tx_start wins: the current rd_bank is sent and the frame goes pending.
//  Length timing
//   tx lengths change only on a swap, so they are stable for the whole of any transmission.
//  Address wrap
//   rx_wr_addr and tx_rd_addr wrap mod 2^ADDR_W; no bounds checking.
//  Reset mid-operation
//   Everything returns to reset values; S_INIT repeats and rewrites bank 0.
//   Frames received before the reset are lost.
// STRUCTURE
//  Package udp_buf_pkg: DEF_PAYLOAD constant array (DEF_WORDS x DATA_W), FSM state enum
//   {S_INIT,S_RUN}, length width LEN_W=16.
//  Sub-module udp_sdp_ram: simple dual-port RAM with depth 2^(ADDR_W+1), one write port,
//   registered read port, one clock.
//  Top module: write mux (init vs rx), bank/busy/pending control, length registers.
// TESTING
//  1. Reset, run 10 clk -> init_done rises at cycle 5; reading bank 0 addresses 0..4 gives
//     DEF_PAYLOAD; lengths are 48/28.
//  2. Idle, write 8 words 0xA0..0xA7, pulse rx_frame_done with lengths 56/36
//     -> next cycle rd_bank=1, tx lengths 56/36, frame_received=1; reads return 0xA0..0xA7.
//  3. tx_start, then a frame with lengths 60/40 during busy -> pending=1, lengths stay 56/36;
//     tx_done -> swap, lengths 60/40.
//  4. While pending, a second frame plus rx writes -> drop_cnt=1, pending bank contents
//     unchanged; 300 drops -> drop_cnt=255.
//  5. tx_start and rx_frame_done in the same cycle -> old bank is read, pending=1;
//     tx_done and rx_frame_done together -> swap and drop_cnt+1.
//  6. Assert reset_n=0 for 1 cycle in mid-transmit -> all outputs return to reset values,
//     bank 0 is re-preloaded, init_done=0 for 5 cycles.

Source files
------------

// File: rtl/udp_buf_pkg.sv
// Shared definitions for the UDP payload ping-pong store: FSM states,
// length width, the default payload preloaded after reset and small helpers.
package udp_buf_pkg;

  localparam int LEN_W         = 16;
  localparam int PKG_DATA_W    = 32;
  localparam int PKG_DEF_WORDS = 5;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Default answer payload ("Hello World!\r\nUDP :)") sent before any frame arrives
  localparam logic [PKG_DATA_W-1:0] DEF_PAYLOAD [PKG_DEF_WORDS] = '{
    32'h4865_6C6C,
    32'h6F20_576F,
    32'h726C_6421,
    32'h0D0A_5544,
    32'h5020_3A29
  };

  // Default payload word k; indices past the table read as zero
  function automatic logic [PKG_DATA_W-1:0] def_payload_word(input logic [31:0] k);
    logic [PKG_DATA_W-1:0] w;
    if (k < 32'(PKG_DEF_WORDS)) begin
      w = DEF_PAYLOAD[k[2:0]];
    end else begin
      w = {PKG_DATA_W{1'b0}};
    end
    return w;
  endfunction

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/udp_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Read data is cleared by the synchronous reset so the sender sees zero after reset.
module udp_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**AW];
  logic [DATA_W-1:0] rdata_r;

  // Storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read, old data returned on a same-address write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/udp_payload_pingpong.sv
// Ping-pong payload store between the GMII UDP rx engine and the sender.
// The rx engine fills wr_bank while the sender reads rd_bank; a completed
// frame swaps the banks (immediately if the sender is idle, otherwise after
// tx_done). Bank 0 is preloaded with a default payload after every reset.
module udp_payload_pingpong
  import udp_buf_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 9,
  parameter int DEF_WORDS     = 5,
  parameter int DEF_TOTAL_LEN = 48,
  parameter int DEF_DATA_LEN  = 28
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_wr_en,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [DATA_W-1:0] rx_wr_data,
  input  logic              rx_frame_done,
  input  logic [LEN_W-1:0]  rx_total_length,
  input  logic [LEN_W-1:0]  rx_data_length,
  input  logic              tx_start,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] tx_rd_addr,
  output logic [DATA_W-1:0] tx_rd_data,
  output logic [LEN_W-1:0]  tx_total_length,
  output logic [LEN_W-1:0]  tx_data_length,
  output logic              init_done,
  output logic              frame_received,
  output logic [7:0]        drop_cnt
);

  localparam int RAM_AW = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEF_TOT_L = LEN_W'(DEF_TOTAL_LEN);
  localparam logic [LEN_W-1:0] DEF_DAT_L = LEN_W'(DEF_DATA_LEN);
  localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(DEF_WORDS - 1);

  state_e            state_r, state_n;
  logic [ADDR_W-1:0] init_cnt_r, init_cnt_n;
  logic              init_done_r, init_done_n;
  logic              wr_bank_r, wr_bank_n;
  logic              rd_bank_r, rd_bank_n;
  logic              busy_r, busy_n;
  logic              pending_r, pending_n;
  logic              frame_received_r, frame_received_n;
  logic [7:0]        drop_cnt_r, drop_cnt_n;
  logic [LEN_W-1:0]  shadow_total_r, shadow_total_n;
  logic [LEN_W-1:0]  shadow_data_r, shadow_data_n;
  logic [LEN_W-1:0]  tx_total_r, tx_total_n;
  logic [LEN_W-1:0]  tx_data_r, tx_data_n;

  logic              run_s;
  logic              frame_done_s;
  logic              start_s;
  logic              done_s;
  logic              swap_now_s;
  logic              swap_pend_s;
  logic              drop_s;
  logic [DATA_W-1:0] init_word_s;

  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [RAM_AW-1:0] ram_raddr_s;

  // Event qualification: rx/tx strobes only count once the preload has finished
  always_comb begin
    run_s        = (state_r == S_RUN);
    frame_done_s = run_s & rx_frame_done;
    start_s      = run_s & tx_start;
    done_s       = run_s & tx_done;
    // idle sender and no start this cycle: the new frame becomes current at once
    swap_now_s   = frame_done_s & ~pending_r & ~busy_r & ~start_s;
    // a parked frame is released when the sender finishes
    swap_pend_s  = pending_r & done_s;
    drop_s       = frame_done_s & pending_r;
    init_word_s  = DATA_W'(def_payload_word(32'(init_cnt_r)));
  end

  // Next-state logic: preload sequencing, busy/pending tracking, bank swap, lengths
  always_comb begin
    state_n          = state_r;
    init_cnt_n       = init_cnt_r;
    init_done_n      = init_done_r;
    wr_bank_n        = wr_bank_r;
    rd_bank_n        = rd_bank_r;
    busy_n           = busy_r;
    pending_n        = pending_r;
    frame_received_n = frame_received_r;
    drop_cnt_n       = drop_cnt_r;
    shadow_total_n   = shadow_total_r;
    shadow_data_n    = shadow_data_r;
    tx_total_n       = tx_total_r;
    tx_data_n        = tx_data_r;

    case (state_r)
      S_INIT: begin
        if (init_cnt_r == LAST_INIT) begin
          state_n     = S_RUN;
          init_done_n = 1'b1;
          init_cnt_n  = {ADDR_W{1'b0}};
        end else begin
          init_cnt_n  = init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end

      S_RUN: begin
        // tx_start is ignored while a transmission is already running
        if (busy_r) begin
          busy_n = ~done_s;
        end else begin
          busy_n = start_s;
        end

        // lengths of a newly accepted frame are held until it becomes current
        if (frame_done_s && !pending_r) begin
          shadow_total_n = rx_total_length;
          shadow_data_n  = rx_data_length;
        end else begin
          shadow_total_n = shadow_total_r;
          shadow_data_n  = shadow_data_r;
        end

        if (swap_now_s) begin
          wr_bank_n        = rd_bank_r;
          rd_bank_n        = wr_bank_r;
          tx_total_n       = rx_total_length;
          tx_data_n        = rx_data_length;
          frame_received_n = 1'b1;
          pending_n        = 1'b0;
        end else if (swap_pend_s) begin
          wr_bank_n        = rd_bank_r;
          rd_bank_n        = wr_bank_r;
          tx_total_n       = shadow_total_r;
          tx_data_n        = shadow_data_r;
          frame_received_n = 1'b1;
          pending_n        = 1'b0;
        end else if (frame_done_s && !pending_r) begin
          pending_n        = 1'b1;
        end else begin
          pending_n        = pending_r;
        end

        if (drop_s) begin
          drop_cnt_n = sat_inc8(drop_cnt_r);
        end else begin
          drop_cnt_n = drop_cnt_r;
        end
      end

      default: begin
        state_n    = S_INIT;
        init_cnt_n = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r          <= S_INIT;
      init_cnt_r       <= {ADDR_W{1'b0}};
      init_done_r      <= 1'b0;
      wr_bank_r        <= 1'b1;
      rd_bank_r        <= 1'b0;
      busy_r           <= 1'b0;
      pending_r        <= 1'b0;
      frame_received_r <= 1'b0;
      drop_cnt_r       <= 8'd0;
      shadow_total_r   <= DEF_TOT_L;
      shadow_data_r    <= DEF_DAT_L;
      tx_total_r       <= DEF_TOT_L;
      tx_data_r        <= DEF_DAT_L;
    end else begin
      state_r          <= state_n;
      init_cnt_r       <= init_cnt_n;
      init_done_r      <= init_done_n;
      wr_bank_r        <= wr_bank_n;
      rd_bank_r        <= rd_bank_n;
      busy_r           <= busy_n;
      pending_r        <= pending_n;
      frame_received_r <= frame_received_n;
      drop_cnt_r       <= drop_cnt_n;
      shadow_total_r   <= shadow_total_n;
      shadow_data_r    <= shadow_data_n;
      tx_total_r       <= tx_total_n;
      tx_data_r        <= tx_data_n;
    end
  end

  // Write-port mux: preload words during init, rx engine afterwards (blocked while a frame is parked)
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = {RAM_AW{1'b0}};
    ram_wdata_s = {DATA_W{1'b0}};
    case (state_r)
      S_INIT: begin
        ram_we_s    = reset_n;
        ram_waddr_s = {1'b0, init_cnt_r};
        ram_wdata_s = init_word_s;
      end
      S_RUN: begin
        ram_we_s    = reset_n & rx_wr_en & ~pending_r;
        ram_waddr_s = {wr_bank_r, rx_wr_addr};
        ram_wdata_s = rx_wr_data;
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {RAM_AW{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
      end
    endcase
    // the sender always reads the other bank, so read and write never collide after init
    ram_raddr_s = {rd_bank_r, tx_rd_addr};
  end

  udp_sdp_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we_s),
    .waddr   (ram_waddr_s),
    .wdata   (ram_wdata_s),
    .raddr   (ram_raddr_s),
    .rdata   (tx_rd_data)
  );

  assign tx_total_length = tx_total_r;
  assign tx_data_length  = tx_data_r;
  assign init_done       = init_done_r;
  assign frame_received  = frame_received_r;
  assign drop_cnt        = drop_cnt_r;

endmodule
